dm_load_unit: RTL and testbench

//  Read side of the data memory. Accepts one load request (LW/LH/LHU/LB/LBU) at a time from the MEM stage.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_load_unit_if.sv | 32 +++
 rtl/dm_load_unit_align.sv | 30 +++
 rtl/dm_load_unit.sv | 137 +++++++++++++
 tb/tb_dm_load_unit.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store path: load opcodes,
// load exception codes and the load-unit state encoding.
package dm_pkg;

    // Load opcodes, common with the store-side decoder
    localparam logic [2:0] LOAD_OP_LW  = 3'b000;
    localparam logic [2:0] LOAD_OP_LH  = 3'b001;
    localparam logic [2:0] LOAD_OP_LHU = 3'b010;
    localparam logic [2:0] LOAD_OP_LB  = 3'b011;
    localparam logic [2:0] LOAD_OP_LBU = 3'b100;

    // Load exception codes returned on the response port
    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    // Load unit FSM states
    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_READ = 2'b01,
        LD_WAIT = 2'b10,
        LD_RESP = 2'b11
    } load_state_e;

endpackage

// File: rtl/dm_load_unit_if.sv
// Bundle of the load unit's request, memory-read and response signals.
// The slave modport is the load unit itself; master is whoever drives it.
interface dm_load_unit_if #(
    parameter int WORD_AW = 12
);
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [31:0]        req_addr;
    logic [31:0]        req_pc;

    logic               mem_rd_en;
    logic [WORD_AW-1:0] mem_addr;
    logic [31:0]        mem_rdata;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic [1:0]         rsp_exc;
    logic [31:0]        rsp_pc;

    modport slave (
        input  req_valid, req_op, req_addr, req_pc, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_exc, rsp_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_pc, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_exc, rsp_pc
    );

endinterface

// File: rtl/dm_load_unit_align.sv
// Combinational byte/half selection and extension of a memory word.
// Lane numbering matches the store byte enables (byte k = word[8k+7:8k]).
module load_align
    import dm_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addrLo_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Pick the addressed lane, then sign- or zero-extend it by opcode
    always_comb begin
        byteSel = word_i[{addrLo_i, 3'b000} +: 8];
        halfSel = addrLo_i[1] ? word_i[31:16] : word_i[15:0];
        data_o  = 32'd0;
        case (op_i)
            LOAD_OP_LW:  data_o = word_i;
            LOAD_OP_LH:  data_o = {{16{halfSel[15]}}, halfSel};
            LOAD_OP_LHU: data_o = {16'd0, halfSel};
            LOAD_OP_LB:  data_o = {{24{byteSel[7]}}, byteSel};
            LOAD_OP_LBU: data_o = {24'd0, byteSel};
            default:     data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// Read side of the data memory: accepts one load at a time, classifies it,
// issues a single word read, waits the fixed memory latency and returns the
// aligned/extended data (or an exception code) on a valid/ready port.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int WORD_AW      = 12
) (
    input logic           Clock,
    input logic           Reset,
    dm_load_unit_if.slave bus
);

    localparam int               CNT_W     = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(READ_LATENCY);

    load_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q;
    logic [1:0]         addrLo_q;
    logic [WORD_AW-1:0] memAddr_q;
    logic [31:0]        rspData_q;
    logic [1:0]         rspExc_q;
    logic [31:0]        rspPc_q;

    logic               fire;
    logic               waitDone;
    logic               outOfRange;
    logic [1:0]         reqExc;
    logic [31:0]        alignedData;

    assign fire       = bus.req_valid && (state_q == LD_IDLE);
    assign waitDone   = (state_q == LD_WAIT) && (cnt_q == CNT_LAST);
    assign outOfRange = (bus.req_addr >> (WORD_AW + 2)) != 32'd0;

    // Classify the incoming request; illegal op beats range beats alignment
    always_comb begin
        reqExc = EXC_OK;
        if (bus.req_op > LOAD_OP_LBU) begin
            reqExc = EXC_ILLEGAL;
        end else if (outOfRange) begin
            reqExc = EXC_RANGE;
        end else if (((bus.req_op == LOAD_OP_LW) && (bus.req_addr[1:0] != 2'b00)) ||
                     (((bus.req_op == LOAD_OP_LH) || (bus.req_op == LOAD_OP_LHU)) &&
                      bus.req_addr[0])) begin
            reqExc = EXC_MISALIGN;
        end
    end

    // State and latency counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and the state-decoded handshake outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.req_ready = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            LD_IDLE: begin
                bus.req_ready = 1'b1;
                if (fire) begin
                    state_d = (reqExc != EXC_OK) ? LD_RESP : LD_READ;
                end
            end
            LD_READ: begin
                bus.mem_rd_en = 1'b1;
                cnt_d         = CNT_FIRST;
                state_d       = LD_WAIT;
            end
            LD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = LD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            LD_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = LD_IDLE;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // Capture the request on fire and the aligned read data at the terminal count
    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q      <= LOAD_OP_LW;
            addrLo_q  <= 2'b00;
            memAddr_q <= '0;
            rspData_q <= 32'd0;
            rspExc_q  <= EXC_OK;
            rspPc_q   <= 32'd0;
        end else begin
            if (fire) begin
                op_q      <= bus.req_op;
                addrLo_q  <= bus.req_addr[1:0];
                rspPc_q   <= bus.req_pc;
                rspExc_q  <= reqExc;
                rspData_q <= 32'd0;
                if (reqExc == EXC_OK) begin
                    memAddr_q <= bus.req_addr[WORD_AW+1:2];
                end
            end
            if (waitDone) begin
                rspData_q <= alignedData;
            end
        end
    end

    load_align u_align (
        .op_i     (op_q),
        .addrLo_i (addrLo_q),
        .word_i   (bus.mem_rdata),
        .data_o   (alignedData)
    );

    assign bus.mem_addr = memAddr_q;
    assign bus.rsp_data = rspData_q;
    assign bus.rsp_exc  = rspExc_q;
    assign bus.rsp_pc   = rspPc_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: two instances (read latency 1 and 3) share one
// stimulus driver; a behavioural model predicts every cycle's handshake and
// response, and directed loads pin literal values.
module tb_dm_load_unit;
    import dm_pkg::*;

    localparam int WORD_AW = 12;

    logic clock = 1'b0;
    logic Reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Stimulus-side variables
    logic        reqValid = 1'b0;
    logic [2:0]  reqOp    = 3'd0;
    logic [31:0] reqAddr  = 32'd0;
    logic [31:0] reqPc    = 32'd0;
    logic        dirReady = 1'b1;
    logic        randReady = 1'b1;
    bit          randMode = 1'b0;
    bit          sel = 1'b0;
    bit          checkEn = 1'b0;
    logic        rspReady;

    int total = 0;
    int bad = 0;
    int rdEnCount = 0;

    logic [31:0] mem [0:(1<<WORD_AW)-1];

    dm_load_unit_if #(.WORD_AW(WORD_AW)) bus1 ();
    dm_load_unit_if #(.WORD_AW(WORD_AW)) bus3 ();

    assign rspReady = randMode ? randReady : dirReady;

    assign bus1.req_valid = reqValid & ~sel;
    assign bus1.req_op    = reqOp;
    assign bus1.req_addr  = reqAddr;
    assign bus1.req_pc    = reqPc;
    assign bus1.rsp_ready = rspReady;
    assign bus3.req_valid = reqValid & sel;
    assign bus3.req_op    = reqOp;
    assign bus3.req_addr  = reqAddr;
    assign bus3.req_pc    = reqPc;
    assign bus3.rsp_ready = rspReady;

    dm_load_unit #(.READ_LATENCY(1), .WORD_AW(WORD_AW)) dut1 (
        .Clock (clock),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    dm_load_unit #(.READ_LATENCY(3), .WORD_AW(WORD_AW)) dut3 (
        .Clock (clock),
        .Reset (Reset),
        .bus   (bus3.slave)
    );

    // Memory models: read data appears exactly 1 or 3 cycles after the strobe,
    // random junk otherwise
    logic [31:0] rd1;
    logic [31:0] rd3a, rd3b, rd3c;
    always @(posedge clock) begin
        rd1  <= bus1.mem_rd_en ? mem[bus1.mem_addr] : $urandom;
        rd3a <= bus3.mem_rd_en ? mem[bus3.mem_addr] : $urandom;
        rd3b <= rd3a;
        rd3c <= rd3b;
        randReady <= ($urandom_range(0, 3) != 0);
    end
    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = rd3c;

    // Outputs of whichever instance is currently selected
    logic        curReqReady, curMemRdEn, curRspValid, curReqValid;
    logic [WORD_AW-1:0] curMemAddr;
    logic [31:0] curRspData, curRspPc;
    logic [1:0]  curRspExc;
    assign curReqValid = sel ? bus3.req_valid : bus1.req_valid;
    assign curReqReady = sel ? bus3.req_ready : bus1.req_ready;
    assign curMemRdEn  = sel ? bus3.mem_rd_en : bus1.mem_rd_en;
    assign curMemAddr  = sel ? bus3.mem_addr  : bus1.mem_addr;
    assign curRspValid = sel ? bus3.rsp_valid : bus1.rsp_valid;
    assign curRspData  = sel ? bus3.rsp_data  : bus1.rsp_data;
    assign curRspExc   = sel ? bus3.rsp_exc   : bus1.rsp_exc;
    assign curRspPc    = sel ? bus3.rsp_pc    : bus1.rsp_pc;

    always @(negedge clock) if (curMemRdEn) rdEnCount++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a load must return, from the load rules alone
    function automatic void modelLoad(input logic [2:0] op, input logic [31:0] addr,
                                      output logic [1:0] exc, output logic [31:0] data);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        exc  = 2'd0;
        data = 32'd0;
        if (op > 3'd4)                      exc = 2'd3;
        else if (addr >= 32'h0000_4000)     exc = 2'd2;
        else if ((op == 3'd0 && addr % 4 != 0) ||
                 ((op == 3'd1 || op == 3'd2) && addr % 2 != 0)) exc = 2'd1;
        if (exc == 2'd0) begin
            w = mem[addr[13:2]];
            b = 8'(w >> (8 * (addr % 4)));
            h = 16'(w >> (8 * (addr % 4)));
            case (op)
                3'd0: data = w;
                3'd1: data = {{16{h[15]}}, h};
                3'd2: data = {16'd0, h};
                3'd3: data = {{24{b[7]}}, b};
                default: data = {24'd0, b};
            endcase
        end
    endfunction

    typedef struct {
        logic [31:0]        data;
        logic [1:0]         exc;
        logic [31:0]        pc;
        int                 validCyc;
        int                 rdCyc;
        logic [WORD_AW-1:0] wordAddr;
        bit                 good;
    } exp_t;

    exp_t expQ[$];
    bit   expValid, expRdEn;
    exp_t e;

    // Cycle-by-cycle compare against the model's outstanding load
    always @(negedge clock) begin
        if (checkEn) begin
            expValid = (expQ.size() > 0) && (cyc >= expQ[0].validCyc);
            expRdEn  = (expQ.size() > 0) && expQ[0].good && (cyc == expQ[0].rdCyc);
            checkOutput("req_ready", 32'(curReqReady), 32'(expQ.size() == 0));
            checkOutput("rsp_valid", 32'(curRspValid), 32'(expValid));
            checkOutput("mem_rd_en", 32'(curMemRdEn), 32'(expRdEn));
            if (expRdEn) checkOutput("mem_addr", 32'(curMemAddr), 32'(expQ[0].wordAddr));
            if (expValid && curRspValid) begin
                checkOutput("rsp_data", curRspData, expQ[0].data);
                checkOutput("rsp_exc", 32'(curRspExc), 32'(expQ[0].exc));
                checkOutput("rsp_pc", curRspPc, expQ[0].pc);
            end
            if (Reset) begin
                expQ.delete();
            end else begin
                if (expValid && curRspValid && rspReady) void'(expQ.pop_front());
                if (curReqValid && curReqReady) begin
                    modelLoad(reqOp, reqAddr, e.exc, e.data);
                    e.pc       = reqPc;
                    e.good     = (e.exc == 2'd0);
                    e.rdCyc    = cyc + 1;
                    e.validCyc = e.good ? cyc + (sel ? 3 : 1) + 2 : cyc + 1;
                    e.wordAddr = reqAddr[13:2];
                    expQ.push_back(e);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] pc, output int fireCyc);
        bit fired = 1'b0;
        fireCyc = -1;
        @(posedge clock); #1;
        reqValid = 1'b1; reqOp = op; reqAddr = addr; reqPc = pc;
        for (int n = 0; n < 100 && !fired; n++) begin
            @(negedge clock);
            if (curReqReady) begin
                fired = 1'b1;
                fireCyc = cyc;
            end
        end
        @(posedge clock); #1;
        reqValid = 1'b0;
        if (!fired) checkOutput("fire_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitRsp(output int rspCyc);
        bit seen = 1'b0;
        rspCyc = -1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clock);
            if (curRspValid) begin
                seen = 1'b1;
                rspCyc = cyc;
            end
        end
        if (!seen) checkOutput("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic directedLoad(input string name, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] expData, input logic [1:0] expExc, input int expLat);
        int f, r;
        applyStimulus(op, addr, 32'h1000 + addr, f);
        waitRsp(r);
        checkOutput({name, "_lat"}, 32'(r - f), 32'(expLat));
        checkOutput({name, "_data"}, curRspData, expData);
        checkOutput({name, "_exc"}, 32'(curRspExc), 32'(expExc));
    endtask

    initial begin
        int lat, f1, f2, r1, snap;
        logic [2:0] op;
        logic [31:0] addr;

        for (int i = 0; i < (1 << WORD_AW); i++) mem[i] = $urandom;
        mem[4] = 32'h8899AABB;

        // Reset state of both instances
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_req_ready1", 32'(bus1.req_ready), 32'd1);
        checkOutput("rst_rsp_valid1", 32'(bus1.rsp_valid), 32'd0);
        checkOutput("rst_mem_rd_en1", 32'(bus1.mem_rd_en), 32'd0);
        checkOutput("rst_mem_addr1", 32'(bus1.mem_addr), 32'd0);
        checkOutput("rst_rsp_data1", bus1.rsp_data, 32'd0);
        checkOutput("rst_rsp_exc1", 32'(bus1.rsp_exc), 32'd0);
        checkOutput("rst_rsp_pc1", bus1.rsp_pc, 32'd0);
        checkOutput("rst_req_ready3", 32'(bus3.req_ready), 32'd1);
        checkOutput("rst_rsp_valid3", 32'(bus3.rsp_valid), 32'd0);
        @(posedge clock); #1;
        Reset = 1'b0;
        checkEn = 1'b1;

        for (int s = 0; s < 2; s++) begin
            @(posedge clock); #1;
            sel = (s == 1);
            lat = sel ? 3 : 1;
            $display("[TB] phase READ_LATENCY=%0d", lat);

            // Good loads from the 0x10 word
            directedLoad("lb12",  LOAD_OP_LB,  32'h12, 32'hFFFFFF99, EXC_OK, lat + 2);
            directedLoad("lbu13", LOAD_OP_LBU, 32'h13, 32'h00000088, EXC_OK, lat + 2);
            directedLoad("lhu10", LOAD_OP_LHU, 32'h10, 32'h0000AABB, EXC_OK, lat + 2);
            directedLoad("lh12",  LOAD_OP_LH,  32'h12, 32'hFFFF8899, EXC_OK, lat + 2);
            directedLoad("lw10",  LOAD_OP_LW,  32'h10, 32'h8899AABB, EXC_OK, lat + 2);

            // Faulting loads: one-cycle response, no memory strobe
            @(posedge clock); #1;
            snap = rdEnCount;
            directedLoad("lw11",   LOAD_OP_LW, 32'h11,       32'd0, EXC_MISALIGN, 1);
            directedLoad("lh4000", LOAD_OP_LH, 32'h00004000, 32'd0, EXC_RANGE,    1);
            directedLoad("op7",    3'b111,     32'h2,        32'd0, EXC_ILLEGAL,  1);
            repeat (2) @(posedge clock); #1;
            checkOutput("fault_no_rd_en", 32'(rdEnCount - snap), 32'd0);

            // Backpressure with an intruding request
            dirReady = 1'b0;
            applyStimulus(LOAD_OP_LW, 32'h10, 32'h400, f1);
            waitRsp(r1);
            @(posedge clock); #1;
            reqValid = 1'b1; reqOp = LOAD_OP_LB; reqAddr = 32'h20; reqPc = 32'hBAD0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                checkOutput("bp_valid", 32'(curRspValid), 32'd1);
                checkOutput("bp_ready", 32'(curReqReady), 32'd0);
                checkOutput("bp_data", curRspData, 32'h8899AABB);
                checkOutput("bp_pc", curRspPc, 32'h400);
            end
            @(posedge clock); #1;
            reqValid = 1'b0;
            dirReady = 1'b1;
            repeat (4) @(posedge clock);

            // Reset in the first WAIT cycle aborts the load
            applyStimulus(LOAD_OP_LW, 32'h10, 32'h500, f1);
            @(posedge clock); #1;
            Reset = 1'b1;
            @(posedge clock); #1;
            Reset = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                checkOutput("rstw_valid", 32'(curRspValid), 32'd0);
                checkOutput("rstw_ready", 32'(curReqReady), 32'd1);
                checkOutput("rstw_data", curRspData, 32'd0);
            end

            // Back-to-back loads
            @(posedge clock); #1;
            snap = rdEnCount;
            applyStimulus(LOAD_OP_LW, 32'h10, 32'h600, f1);
            applyStimulus(LOAD_OP_LW, 32'h24, 32'h604, f2);
            checkOutput("b2b_spacing", 32'(f2 - f1), 32'(lat + 3));
            waitRsp(r1);
            checkOutput("b2b_lat", 32'(r1 - f2), 32'(lat + 2));
            checkOutput("b2b_pc", curRspPc, 32'h604);
            repeat (3) @(posedge clock); #1;
            checkOutput("b2b_rd_en_pulses", 32'(rdEnCount - snap), 32'd2);

            // Randomized loads with random response backpressure
            randMode = 1'b1;
            for (int i = 0; i < 120; i++) begin
                op = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 4));
                addr = $urandom_range(0, 32'h3FFF);
                if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
                if ($urandom_range(0, 9) == 0) addr = $urandom;
                applyStimulus(op, addr, $urandom, f1);
                repeat ($urandom_range(0, 2)) @(posedge clock);
            end
            begin
                bit idle = 1'b0;
                for (int n = 0; n < 80 && !idle; n++) begin
                    @(negedge clock);
                    if (curReqReady) idle = 1'b1;
                end
                if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
            end
            @(posedge clock); #1;
            randMode = 1'b0;
            repeat (2) @(posedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
